// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction loader.
package loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [1:0] {
    S_HDR,
    S_DATA,
    S_RUN,
    S_ERR
  } loader_state_t;

endpackage : loader_pkg

// File: rtl/imem_loader_byte_assembler.sv
// Little-endian byte-to-word assembler shared by header and data words.
// Only the three earlier bytes are stored. The fourth byte is routed straight
// into word_o, so the completed word is available in the cycle it arrives.
module byte_assembler
  import loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              accept_i,
  input  logic [7:0]        data_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [WORD_W-9:0] shift_q, shift_d;
  logic [1:0]        idx_q, idx_d;

  // Shift each accepted byte in from the top, so the first byte ends up in bits 7:0.
  always_comb begin
    shift_d = shift_q;
    idx_d   = idx_q;
    if (clear_i) begin
      shift_d = '0;
      idx_d   = '0;
    end else if (accept_i) begin
      shift_d = {data_i, shift_q[WORD_W-9:8]};
      idx_d   = idx_q + 2'd1;
    end
  end

  // Byte history and byte index registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
      idx_q   <= '0;
    end else begin
      shift_q <= shift_d;
      idx_q   <= idx_d;
    end
  end

  assign word_o      = {data_i, shift_q};
  assign word_done_o = accept_i && (idx_q == 2'(BYTES_PER_WORD - 1));

endmodule : byte_assembler

// File: rtl/imem_loader.sv
// Boot loader: parses a length-prefixed byte stream into instruction-memory
// writes and holds the CPU in reset until the load completes.
module imem_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_data,
  input  logic              reload,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  // Capacity 2^ADDR_W, widened past WORD_W so the full header compares cleanly.
  localparam logic [WORD_W:0] CAP = {{WORD_W{1'b0}}, 1'b1} << ADDR_W;

  loader_state_t     state_q, state_d;
  logic [ADDR_W:0]   wcnt_q, wcnt_d, wcnt_inc;
  logic [ADDR_W:0]   n_q, n_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              cpu_rst_q, done_q, error_q;
  logic              accept, clear, word_done;
  logic [WORD_W-1:0] word;

  assign in_ready = (state_q == S_HDR) || (state_q == S_DATA);
  assign accept   = in_valid && in_ready;
  assign wcnt_inc = wcnt_q + {{ADDR_W{1'b0}}, 1'b1};

  byte_assembler u_asm (
    .clk_i       (clk),
    .rst_ni      (rst),
    .clear_i     (clear),
    .accept_i    (accept),
    .data_i      (in_data),
    .word_o      (word),
    .word_done_o (word_done)
  );

  // Next-state, counter and write-port logic.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    n_d     = n_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    clear   = 1'b0;
    unique case (state_q)
      S_HDR: begin
        if (word_done) begin
          n_d    = word[ADDR_W:0];
          wcnt_d = '0;
          if ({1'b0, word} > CAP)  state_d = S_ERR;
          else if (word == '0)     state_d = S_RUN;
          else                     state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (word_done) begin
          we_d    = 1'b1;
          addr_d  = wcnt_q[ADDR_W-1:0];
          wdata_d = word;
          wcnt_d  = wcnt_inc;
          if (wcnt_inc == n_q) state_d = S_RUN;
        end
      end
      S_RUN, S_ERR: begin
        if (reload) begin
          state_d = S_HDR;
          wcnt_d  = '0;
          clear   = 1'b1;
        end
      end
      default: state_d = S_HDR;
    endcase
  end

  // Status outputs follow the state one cycle later, so release trails the final write pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_HDR;
      wcnt_q    <= '0;
      n_q       <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      n_q       <= n_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      cpu_rst_q <= (state_q != S_RUN);
      done_q    <= (state_q == S_RUN);
      error_q   <= (state_q == S_ERR);
    end
  end

  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// Directed and randomized checks of imem_loader against a word-list model.
module tb_imem_loader;

  localparam int unsigned AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          reload;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cpu_rst;
  logic          done;
  logic          error;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } wr_t;

  wr_t         got[$];
  logic [31:0] words[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .reload    (reload),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .cpu_rst   (cpu_rst),
    .done      (done),
    .error     (error)
  );

  // Log every write pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (mem_we === 1'b1) got.push_back(wr_t'{a: mem_addr, d: mem_wdata});
  end

  initial begin
    #1ms;
    $error("FAIL watchdog: simulation still running, required finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // mode 0: back-to-back, 1: valid every third cycle, 2: random gaps
  task automatic send_byte(input logic [7:0] b, input int mode);
    if (mode == 1) idle(2);
    else if (mode == 2) idle(int'($urandom_range(0, 3)));
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  task automatic send_word(input logic [31:0] w, input int mode);
    for (int unsigned b = 0; b < 4; b++) send_byte(w[8*b +: 8], mode);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
    idle(1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, " mem_we"}, 64'(mem_we), 64'd0);
    chk({tag, " mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, " mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, " cpu_rst"}, 64'(cpu_rst), 64'd1);
    chk({tag, " done"}, 64'(done), 64'd0);
    chk({tag, " error"}, 64'(error), 64'd0);
  endtask

  // Send header + words, then compare release timing and the write log to the word list.
  task automatic load_check(input string tag, input int mode);
    int unsigned n;
    n = words.size();
    got.delete();
    send_word(32'(n), mode);
    if (n == 0) begin
      chk({tag, " cpu_rst held"}, 64'(cpu_rst), 64'd1);
      idle(1);
    end else begin
      for (int unsigned i = 0; i < n; i++) send_word(words[i], mode);
      chk({tag, " last we"}, 64'(mem_we), 64'd1);
      chk({tag, " last addr"}, 64'(mem_addr), 64'(n - 1));
      chk({tag, " last data"}, 64'(mem_wdata), 64'(words[n-1]));
      chk({tag, " cpu_rst held"}, 64'(cpu_rst), 64'd1);
      chk({tag, " done early"}, 64'(done), 64'd0);
      idle(1);
      chk({tag, " we drop"}, 64'(mem_we), 64'd0);
    end
    chk({tag, " cpu_rst release"}, 64'(cpu_rst), 64'd0);
    chk({tag, " done"}, 64'(done), 64'd1);
    chk({tag, " in_ready run"}, 64'(in_ready), 64'd0);
    idle(2);
    chk({tag, " pulse count"}, 64'(got.size()), 64'(n));
    for (int unsigned i = 0; i < n && i < got.size(); i++) begin
      chk($sformatf("%s addr[%0d]", tag, i), 64'(got[i].a), 64'(i % (1 << AW)));
      chk($sformatf("%s data[%0d]", tag, i), 64'(got[i].d), 64'(words[i]));
    end
  endtask

  task automatic spec_words();
    words.delete();
    words.push_back(32'h20080005);
    words.push_back(32'h20090007);
    words.push_back(32'h01095020);
  endtask

  task automatic overflow_case(input string tag, input logic [31:0] hdr);
    got.delete();
    send_word(hdr, 0);
    idle(1);
    chk({tag, " error"}, 64'(error), 64'd1);
    chk({tag, " in_ready"}, 64'(in_ready), 64'd0);
    chk({tag, " cpu_rst"}, 64'(cpu_rst), 64'd1);
    chk({tag, " done"}, 64'(done), 64'd0);
    send_word($urandom, 0);
    send_word($urandom, 0);
    idle(1);
    chk({tag, " error stays"}, 64'(error), 64'd1);
    chk({tag, " no writes"}, 64'(got.size()), 64'd0);
    pulse_reload();
    chk({tag, " error clear"}, 64'(error), 64'd0);
    chk({tag, " in_ready back"}, 64'(in_ready), 64'd1);
    chk({tag, " cpu_rst kept"}, 64'(cpu_rst), 64'd1);
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    reload   = 1'b0;
    idle(2);
    check_reset_outputs("rst low");
    rst = 1'b1;
    idle(1);
    check_reset_outputs("after rst");

    // Basic three-word load
    spec_words();
    load_check("load3", 0);

    // Reload from run state, then an empty load
    pulse_reload();
    chk("reload cpu_rst", 64'(cpu_rst), 64'd1);
    chk("reload done", 64'(done), 64'd0);
    chk("reload in_ready", 64'(in_ready), 64'd1);
    words.delete();
    load_check("empty", 0);

    // Header just over capacity, and one whose excess sits in the upper bits
    pulse_reload();
    overflow_case("ovf257", 32'd257);
    overflow_case("ovfhi", 32'h0001_0001);

    // Throttled input
    spec_words();
    load_check("throttle", 1);

    // Reset after two bytes of word 1
    pulse_reload();
    got.delete();
    send_word(32'd3, 0);
    send_word(words[0], 0);
    send_byte(words[1][7:0], 0);
    send_byte(words[1][15:8], 0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    idle(2);
    check_reset_outputs("midrst hold");
    rst = 1'b1;
    idle(1);
    load_check("post rst", 0);

    // Random words with random gaps
    pulse_reload();
    words.delete();
    for (int unsigned i = 0; i < 5; i++) words.push_back($urandom);
    load_check("random", 2);

    // Exactly full memory, value = address
    pulse_reload();
    words.delete();
    for (int unsigned i = 0; i < 256; i++) words.push_back(32'(i));
    load_check("full", 0);

    // Reload and a single word
    pulse_reload();
    words.delete();
    words.push_back(32'hDEADBEEF);
    load_check("single", 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_imem_loader
